seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Bus-mapped controller that time-multiplexes the four-digit seven-segment display. It holds digit contents written by the CPU over the peripheral bus, decodes hex or passes raw segment patterns, and scans the digits with a configurable refresh period, brightness duty cycle and anti-ghosting guard. It sits inside the bus fabric and drives the board-level `sel`/`seg` nets, which the top level may still override from GPIO.

## Interface
- `SCAN_DIV`, 25000: clock cycles per digit slot; must be ≥ `GUARD`+16.
- `GUARD`, 16: cycles at the start of each slot with all digits off.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `wr_en`  in  1  register write strobe, one cycle per write.
- `addr`  in  2  register index.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, registered.
- `sel`  out  4  digit enables, active-low one-hot; 4'hF means all off.
- `seg`  out  8  segments {dp,g,f,e,d,c,b,a}, active-low; 8'hFF means all off.

## Operation
- Register map, addressed by `addr`. Each register has a shadow copy, which is what bus writes update, and an active copy, which drives the display.
  - 0 DATA: [15:0] four hex nibbles; nibble k is digit k.
  - 1 CTRL: [3:0] decimal point per digit; [7:4] blank per digit; [8] raw mode; [15:12] brightness.
  - 2 RAW: byte k is the active-low segment pattern for digit k, used when raw mode is set.
  - 3 STATUS: read-only; [1:0] current digit, [2] frame toggle. Writes to it are ignored.
- `rdata` returns the shadow value of DATA/CTRL/RAW, or live STATUS. Unused bits read 0.
- Shadow-to-active copy happens only at the frame boundary, i.e. when the digit index wraps from 3 to 0. This prevents a half-updated display.
- Scan counter `div_cnt` runs 0..SCAN_DIV-1. At terminal count it returns to 0 and the digit index advances 0→1→2→3→0. Each 3→0 wrap flips the frame toggle.
- Brightness: a 4-bit free-running `pwm_cnt` increments every cycle. The digit is lit when `pwm_cnt` ≤ brightness, giving a duty of (brightness+1)/16.
- A digit is driven (sel bit low, seg = pattern) only when all of these hold:
  - `div_cnt` ≥ GUARD;
  - the digit is not blanked;
  - the PWM condition is true.
- Otherwise `sel`=4'hF and `seg`=8'hFF.
- Pattern selection:
  - Raw mode: RAW byte k, with dp bit ANDed low if dp[k] is set.
  - Hex mode: active-low decode of the nibble (0–9, A–F standard glyphs); dp segment low if dp[k] is set.

## Timing
- Reset values:
  - Registers: DATA=0, CTRL=16'hF000 (full brightness, no blanking, hex mode), RAW=32'hFFFF_FFFF, applied to both shadow and active copies.
  - Counters: `div_cnt`=0, `pwm_cnt`=0, digit=0, frame toggle=0.
  - Outputs: `sel`=4'hF, `seg`=8'hFF, `rdata`=0.
- Reset asserted mid-scan or mid-frame reaches these values on the next edge; there is no partial completion.
- `sel` and `seg` are registered: they reflect the counter and register state one cycle later.
- `rdata` is valid one cycle after `addr` is presented.
- A write updates the shadow on the same edge.
  - The write is visible on `rdata` one cycle later.
  - On the display it appears after the next 3→0 boundary plus one output cycle.
- A write coinciding with the boundary cycle: the commit captures the pre-write shadow, and the new value commits at the following boundary.
- Back-to-back writes to one register: the last write wins.
- Frame period is 4×SCAN_DIV cycles.

## Structure
- A shared package holds:
  - register address constants (DATA/CTRL/RAW/STATUS);
  - CTRL field positions;
  - the reset constants;
  - the 16-entry active-low hex glyph table.
- Sub-module `seg_hex_decode`: purely combinational nibble plus dp to 8-bit active-low pattern.
- Everything else (register file, shadow/active copy, scan and PWM counters, output registers) lives in `seg_scan_ctrl`.

## Test plan
- Reset → `sel`=4'hF and `seg`=8'hFF for the first GUARD+1 cycles; afterwards digit 0 shows glyph "0" (8'hC0) with `sel`=4'b1110.
- Write DATA=16'h1234 while digit 1 is active → display unchanged until the 3→0 wrap. The next frame shows digit0=4 (8'h99), digit1=3 (8'hB0), digit2=2 (8'hA4), digit3=1 (8'hF9).
- CTRL brightness=3 → within each slot, after GUARD, the digit is lit exactly 4 of every 16 cycles.
- CTRL=0x0120 (raw mode, digit 1 blanked), RAW=32'h00FF_7F08 → digit 0 outputs 8'h08, digit 1 stays dark (`sel`=4'hF), digit 2 outputs 8'hFF, digit 3 outputs 8'h00.
- Write DATA exactly on the boundary cycle → committed one frame later. STATUS read shows the frame toggle flipping once per 4×SCAN_DIV cycles.
- Assert `reset` mid-slot with non-default registers → next cycle all registers, counters and outputs equal their reset values.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// rtl/seg_scan_ctrl_pkg.sv - shared constants and types for the seven-segment scan controller
//
// Purpose: register addresses, CTRL field layout, reset values and the
// active-low hex glyph table used by seg_scan_ctrl and seg_hex_decode.
// Ports: none (package).
package seg_scan_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_RAW    = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_DP_LSB     = 0;
  localparam int CTRL_BLANK_LSB  = 4;
  localparam int CTRL_RAW_BIT    = 8;
  localparam int CTRL_BRIGHT_LSB = 12;

  // Only the defined CTRL bits are stored; the rest read back as zero.
  typedef struct packed {
    logic [3:0] bright;
    logic       raw_mode;
    logic [3:0] blank;
    logic [3:0] dp;
  } ctrl_t;

  localparam logic [15:0] DATA_RST = 16'h0000;
  localparam ctrl_t       CTRL_RST = '{bright: 4'hF, raw_mode: 1'b0, blank: 4'h0, dp: 4'h0};
  localparam logic [31:0] RAW_RST  = 32'hFFFF_FFFF;

  localparam logic [3:0] SEL_OFF = 4'hF;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // {dp,g,f,e,d,c,b,a}, active-low, dp off; entry n is the glyph for nibble n.
  localparam logic [15:0][7:0] HEX_GLYPH = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [15:0] ctrl_pack(input ctrl_t c);
    logic [15:0] w;
    w = '0;
    w[CTRL_DP_LSB +: 4]     = c.dp;
    w[CTRL_BLANK_LSB +: 4]  = c.blank;
    w[CTRL_RAW_BIT]         = c.raw_mode;
    w[CTRL_BRIGHT_LSB +: 4] = c.bright;
    return w;
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational hex nibble to active-low segment pattern
//
// Purpose: map a nibble to its seven-segment glyph and optionally light dp.
// Ports:
//   nibble_i  in  4  hex digit value
//   dp_i      in  1  light the decimal point
//   seg_o     out 8  {dp,g,f,e,d,c,b,a}, active-low
module seg_hex_decode
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  assign seg_o = HEX_GLYPH[nibble_i] & ~{dp_i, 7'b000_0000};

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - bus-mapped four-digit seven-segment scan controller
//
// Purpose: register file with shadow/active copies, digit scan and PWM
// counters, and registered digit/segment outputs.
// Ports:
//   clk_i     in  1   system clock, rising edge
//   reset_i   in  1   synchronous, active-high
//   wr_en_i   in  1   register write strobe
//   addr_i    in  2   register index (DATA/CTRL/RAW/STATUS)
//   wdata_i   in  32  write data
//   rdata_o   out 32  registered read data
//   sel_o     out 4   digit enables, active-low one-hot
//   seg_o     out 8   segments {dp,g,f,e,d,c,b,a}, active-low
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 25000,  // cycles per digit slot, >= GUARD+16
  parameter int unsigned GUARD    = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        wr_en_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic [3:0]  sel_o,
  output logic [7:0]  seg_o
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] GUARD_END = DIV_W'(GUARD);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       pwm_cnt_q, pwm_cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic             frame_q, frame_d;

  logic [15:0] shadow_data_q, shadow_data_d, active_data_q, active_data_d;
  ctrl_t       shadow_ctrl_q, shadow_ctrl_d, active_ctrl_q, active_ctrl_d;
  logic [31:0] shadow_raw_q, shadow_raw_d, active_raw_q, active_raw_d;

  logic [3:0]  sel_q, sel_d;
  logic [7:0]  seg_q, seg_d;
  logic [31:0] rdata_q, rdata_d;

  logic       div_wrap;
  logic       frame_wrap;
  logic       lit;
  logic [7:0] hex_pat;
  logic [7:0] raw_pat;

  assign div_wrap   = (div_cnt_q == DIV_LAST);
  assign frame_wrap = div_wrap && (digit_q == 2'd3);

  seg_hex_decode u_hex (
    .nibble_i (active_data_q[{digit_q, 2'b00} +: 4]),
    .dp_i     (active_ctrl_q.dp[digit_q]),
    .seg_o    (hex_pat)
  );

  assign raw_pat = active_raw_q[{digit_q, 3'b000} +: 8] & ~{active_ctrl_q.dp[digit_q], 7'b000_0000};

  // Counters and register file next state.
  always_comb begin
    div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
    pwm_cnt_d = pwm_cnt_q + 4'd1;
    digit_d   = div_wrap ? digit_q + 2'd1 : digit_q;
    frame_d   = frame_q ^ frame_wrap;

    shadow_data_d = shadow_data_q;
    shadow_ctrl_d = shadow_ctrl_q;
    shadow_raw_d  = shadow_raw_q;
    if (wr_en_i) begin
      case (addr_i)
        ADDR_DATA: shadow_data_d = wdata_i[15:0];
        ADDR_CTRL: shadow_ctrl_d = '{bright:   wdata_i[CTRL_BRIGHT_LSB +: 4],
                                     raw_mode: wdata_i[CTRL_RAW_BIT],
                                     blank:    wdata_i[CTRL_BLANK_LSB +: 4],
                                     dp:       wdata_i[CTRL_DP_LSB +: 4]};
        ADDR_RAW:  shadow_raw_d  = wdata_i;
        default:   ;  // STATUS is read-only
      endcase
    end

    // Commit takes the shadow as it stood before this edge, so a write on
    // the boundary cycle lands one frame later.
    active_data_d = frame_wrap ? shadow_data_q : active_data_q;
    active_ctrl_d = frame_wrap ? shadow_ctrl_q : active_ctrl_q;
    active_raw_d  = frame_wrap ? shadow_raw_q  : active_raw_q;
  end

  // Display and read-back next state.
  always_comb begin
    lit = (div_cnt_q >= GUARD_END) && !active_ctrl_q.blank[digit_q] &&
          (pwm_cnt_q <= active_ctrl_q.bright);
    sel_d = SEL_OFF;
    seg_d = SEG_OFF;
    if (lit) begin
      sel_d = ~(4'b0001 << digit_q);
      seg_d = active_ctrl_q.raw_mode ? raw_pat : hex_pat;
    end

    case (addr_i)
      ADDR_DATA: rdata_d = {16'h0000, shadow_data_q};
      ADDR_CTRL: rdata_d = {16'h0000, ctrl_pack(shadow_ctrl_q)};
      ADDR_RAW:  rdata_d = shadow_raw_q;
      default:   rdata_d = {29'd0, frame_q, digit_q};
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_cnt_q     <= '0;
      pwm_cnt_q     <= '0;
      digit_q       <= '0;
      frame_q       <= 1'b0;
      shadow_data_q <= DATA_RST;
      active_data_q <= DATA_RST;
      shadow_ctrl_q <= CTRL_RST;
      active_ctrl_q <= CTRL_RST;
      shadow_raw_q  <= RAW_RST;
      active_raw_q  <= RAW_RST;
      sel_q         <= SEL_OFF;
      seg_q         <= SEG_OFF;
      rdata_q       <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      digit_q       <= digit_d;
      frame_q       <= frame_d;
      shadow_data_q <= shadow_data_d;
      active_data_q <= active_data_d;
      shadow_ctrl_q <= shadow_ctrl_d;
      active_ctrl_q <= active_ctrl_d;
      shadow_raw_q  <= shadow_raw_d;
      active_raw_q  <= active_raw_d;
      sel_q         <= sel_d;
      seg_q         <= seg_d;
      rdata_q       <= rdata_d;
    end
  end

  assign sel_o   = sel_q;
  assign seg_o   = seg_q;
  assign rdata_o = rdata_q;

endmodule
